// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module  : mem_arb_pkg
// Purpose : Shared types and constants for the two-port RAM arbiter:
//           FSM state encoding, default widths, port indices and a helper
//           for loading the read-latency counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  localparam int unsigned ARB_ADDR_W = 9;
  localparam int unsigned ARB_DATA_W = 32;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  // Counter preload for the WAIT state; legal read latencies 1..4 fit in 2 bits.
  function automatic logic [1:0] lat_init(input int unsigned rd_lat);
    return 2'(rd_lat - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_arb2_select.sv
// ============================================================================
// Module  : arb2_select
// Purpose : Combinational winner selection between the CPU port (index 0)
//           and the loader port (index 1).
//           MEM_ARB_ROUND_ROBIN_EN defined  : ties go to the port that did
//                                             not win last time.
//           MEM_ARB_ROUND_ROBIN_EN undefined: the CPU port always wins ties.
//           A lone requester always wins in either build.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module arb2_select
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       valid_o,
  output logic       grant_o
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
  // Fixed priority has no use for the grant history.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

  // Pick the winning port index; grant_o is meaningless while valid_o is low.
  always_comb begin
    valid_o = |req_i;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (&req_i) begin
      grant_o = ~last_grant_i;
    end else begin
      grant_o = req_i[PORT_CPU] ? PORT_CPU : PORT_LDR;
    end
`else
    grant_o = req_i[PORT_CPU] ? PORT_CPU : PORT_LDR;
`endif
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module  : mem_port_arbiter
// Purpose : Serialises CPU (p0) and loader (p1) accesses onto a single-port
//           RAM, one transaction in flight at a time.
//           IDLE -> ACCESS -> RESP             (write)
//           IDLE -> ACCESS -> WAIT x RD_LAT -> RESP (read)
//           Optional macro MEM_ARB_ROUND_ROBIN_EN selects round-robin tie
//           breaking (default build: fixed priority, CPU wins).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ARB_ADDR_W,
  parameter int unsigned DATA_W = ARB_DATA_W,
  parameter int unsigned RD_LAT = 1           // legal range 1..4
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              p0_req_i,
  input  logic              p0_we_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_wdata_i,
  output logic              p0_ack_o,
  output logic [DATA_W-1:0] p0_rdata_o,

  input  logic              p1_req_i,
  input  logic              p1_we_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_wdata_i,
  output logic              p1_ack_o,
  output logic [DATA_W-1:0] p1_rdata_o,

  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic              ram_we_o,
  output logic              ram_re_o,
  input  logic [DATA_W-1:0] ram_rdata_i,

  output logic              busy_o
);

  arb_state_e        state_q;
  logic              grant_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        lat_cnt_q;
  logic              ram_we_q;
  logic              ram_re_q;
  logic              p0_ack_q;
  logic              p1_ack_q;
  logic [DATA_W-1:0] p0_rdata_q;
  logic [DATA_W-1:0] p1_rdata_q;

  logic              last_grant;
  logic              sel_valid;
  logic              sel_port;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant_q;
  assign last_grant = last_grant_q;
`else
  // No history register: the selector ignores it in this build.
  assign last_grant = PORT_LDR;
`endif

  arb2_select u_sel (
    .req_i        ({p1_req_i, p0_req_i}),
    .last_grant_i (last_grant),
    .valid_o      (sel_valid),
    .grant_o      (sel_port)
  );

  // Winner's request fields; the loser's inputs never reach the latches.
  assign win_we    = (sel_port == PORT_LDR) ? p1_we_i    : p0_we_i;
  assign win_addr  = (sel_port == PORT_LDR) ? p1_addr_i  : p0_addr_i;
  assign win_wdata = (sel_port == PORT_LDR) ? p1_wdata_i : p0_wdata_i;

  // Transaction FSM with registered RAM strobes, acks and read-data capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      grant_q      <= PORT_CPU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      lat_cnt_q    <= 2'd0;
      ram_we_q     <= 1'b0;
      ram_re_q     <= 1'b0;
      p0_ack_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= PORT_LDR;
`endif
    end else begin
      // Strobes and acks are single-cycle pulses unless re-armed below.
      ram_we_q <= 1'b0;
      ram_re_q <= 1'b0;
      p0_ack_q <= 1'b0;
      p1_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sel_valid) begin
            grant_q  <= sel_port;
            we_q     <= win_we;
            addr_q   <= win_addr;
            wdata_q  <= win_wdata;
            // Arm the strobe now so it is high exactly during ACCESS.
            ram_we_q <= win_we;
            ram_re_q <= ~win_we;
            state_q  <= ACCESS;
          end
        end
        ACCESS: begin
          if (we_q) begin
            p0_ack_q <= (grant_q == PORT_CPU);
            p1_ack_q <= (grant_q == PORT_LDR);
            state_q  <= RESP;
          end else begin
            lat_cnt_q <= lat_init(RD_LAT);
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt_q == 2'd0) begin
            if (grant_q == PORT_CPU) begin
              p0_rdata_q <= ram_rdata_i;
            end else begin
              p1_rdata_q <= ram_rdata_i;
            end
            p0_ack_q <= (grant_q == PORT_CPU);
            p1_ack_q <= (grant_q == PORT_LDR);
            state_q  <= RESP;
          end else begin
            lat_cnt_q <= lat_cnt_q - 2'd1;
          end
        end
        RESP: begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_q <= grant_q;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;
  assign ram_we_o    = ram_we_q;
  assign ram_re_o    = ram_re_q;
  assign p0_ack_o    = p0_ack_q;
  assign p1_ack_o    = p1_ack_q;
  assign p0_rdata_o  = p0_rdata_q;
  assign p1_rdata_o  = p1_rdata_q;
  assign busy_o      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module  : tb_mem_port_arbiter
// Purpose : Self-checking bench for mem_port_arbiter (RD_LAT = 2). Honours
//           MEM_ARB_ROUND_ROBIN_EN for the expected tie-break order.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW     = 9;
  localparam int DW     = 32;
  localparam int RD_LAT = 2;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_ram = 1'b1;
  logic rand_en = 1'b0;

  logic [1:0]    req_v = 2'b00;
  logic [1:0]    we_v  = 2'b00;
  logic [AW-1:0] addr_v [2];
  logic [DW-1:0] wdata_v [2];
  int            gap [2];
  req_t          q0 [$];
  req_t          q1 [$];
  int            ack_log [$];

  logic          p0_ack, p1_ack, ram_we, ram_re, busy;
  logic [DW-1:0] p0_rdata, p1_rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;
  logic [1:0]    ack_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign ack_w = {p1_ack, p0_ack};

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .p0_req_i    (req_v[0]),
    .p0_we_i     (we_v[0]),
    .p0_addr_i   (addr_v[0]),
    .p0_wdata_i  (wdata_v[0]),
    .p0_ack_o    (p0_ack),
    .p0_rdata_o  (p0_rdata),
    .p1_req_i    (req_v[1]),
    .p1_we_i     (we_v[1]),
    .p1_addr_i   (addr_v[1]),
    .p1_wdata_i  (wdata_v[1]),
    .p1_ack_o    (p1_ack),
    .p1_rdata_o  (p1_rdata),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_we_o    (ram_we),
    .ram_re_o    (ram_re),
    .ram_rdata_i (ram_rdata),
    .busy_o      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // RAM: write on ram_we, read data appears RD_LAT cycles after ram_re;
  // cycles without a read fill the pipe with noise.
  logic [DW-1:0] ram [512];
  logic [DW-1:0] pipe [RD_LAT];
  always @(posedge clk) begin
    if (init_ram) begin
      for (int i = 0; i < 512; i++) ram[i] <= DW'(i * 7 + 1);
    end else if (ram_we) begin
      ram[ram_addr] <= ram_wdata;
    end
    pipe[0] <= ram_re ? ram[ram_addr] : DW'($urandom);
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_rdata = pipe[RD_LAT-1];

  // Reference model: a transaction occupies a fixed number of cycles after
  // being sampled (write 2, read 2+RD_LAT); strobe in the first, ack in the last.
  logic [DW-1:0] mdl_mem [512];
  int            phase = 0;
  int            len   = 0;
  logic          g     = 1'b0;
  logic          lastg = 1'b1;
  logic          m_we  = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rd = '0;
  logic          exp_busy = 1'b0, exp_we = 1'b0, exp_re = 1'b0;
  logic [1:0]    exp_ack = 2'b00;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
  logic [DW-1:0] exp_rdata [2] = '{default: '0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase = 0; lastg = 1'b1;
      exp_busy = 0; exp_we = 0; exp_re = 0; exp_ack = 2'b00;
      exp_addr = '0; exp_wdata = '0;
      exp_rdata[0] = '0; exp_rdata[1] = '0;
      if (init_ram) for (int i = 0; i < 512; i++) mdl_mem[i] = DW'(i * 7 + 1);
    end else begin
      exp_we = 0; exp_re = 0; exp_ack = 2'b00;
      if (phase == 0) begin
        if (req_v != 2'b00) begin
          if (req_v == 2'b11) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            g = ~lastg;
`else
            g = 1'b0;
`endif
          end else begin
            g = (req_v == 2'b10);
          end
          m_we = we_v[g]; m_addr = addr_v[g]; m_wdata = wdata_v[g];
          len = m_we ? 2 : 2 + RD_LAT;
          phase = 1;
        end
      end else if (phase == len) begin
        phase = 0;
        lastg = g;
      end else begin
        phase++;
      end
      if (phase == 1) begin
        exp_addr = m_addr; exp_wdata = m_wdata;
        exp_we = m_we; exp_re = !m_we;
        if (m_we) mdl_mem[m_addr] = m_wdata;
        else      m_rd = mdl_mem[m_addr];
      end
      if (phase != 0 && phase == len) begin
        exp_ack[g] = 1'b1;
        if (!m_we) exp_rdata[g] = m_rd;
      end
      exp_busy = (phase != 0);
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("busy",      busy,      exp_busy);
    chk("ram_we",    ram_we,    exp_we);
    chk("ram_re",    ram_re,    exp_re);
    chk("ram_addr",  ram_addr,  exp_addr);
    chk("ram_wdata", ram_wdata, exp_wdata);
    chk("p0_ack",    p0_ack,    exp_ack[0]);
    chk("p1_ack",    p1_ack,    exp_ack[1]);
    chk("p0_rdata",  p0_rdata,  exp_rdata[0]);
    chk("p1_rdata",  p1_rdata,  exp_rdata[1]);
    chk("we_re_excl", ram_we & ram_re, 1'b0);
    if (p0_ack) ack_log.push_back(0);
    if (p1_ack) ack_log.push_back(1);
  end

  // Requester behaviour: hold req until ack, drop it in the ack cycle,
  // then issue the next scripted (or random) request after a gap.
  task automatic drive(input int p);
    req_t r;
    logic have;
    have = 1'b0;
    r = '0;
    if (rst) begin
      req_v[p] = 1'b0; gap[p] = 0;
    end else if (req_v[p]) begin
      if (ack_w[p]) begin
        req_v[p] = 1'b0;
        gap[p] = rand_en ? int'($urandom_range(0, 3)) : 0;
      end
    end else if (gap[p] > 0) begin
      gap[p]--;
      addr_v[p] = AW'($urandom);
    end else begin
      if (p == 0 && q0.size() > 0) begin
        r = q0.pop_front(); have = 1'b1;
      end else if (p == 1 && q1.size() > 0) begin
        r = q1.pop_front(); have = 1'b1;
      end else if (rand_en && $urandom_range(0, 1) == 1) begin
        r.we = 1'($urandom); r.addr = AW'($urandom_range(0, 15)); r.data = $urandom;
        have = 1'b1;
      end
      if (have) begin
        req_v[p] = 1'b1; we_v[p] = r.we; addr_v[p] = r.addr; wdata_v[p] = r.data;
      end
    end
  endtask

  initial begin
    addr_v[0] = '0; addr_v[1] = '0; wdata_v[0] = '0; wdata_v[1] = '0;
    gap[0] = 0; gap[1] = 0;
    forever begin
      @(negedge clk);
      drive(0);
      drive(1);
    end
  end

  task automatic wait_quiet(input string tag, input int budget);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || req_v != 2'b00 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n < budget, 1'b1);
    @(negedge clk);
  endtask

  task automatic wait_model_wait(input string tag, input int budget);
    int n = 0;
    while (phase != 2 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n < budget, 1'b1);
  endtask

  initial begin
    int exp_order [4];
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 0};
`else
    exp_order = '{0, 0, 0, 1};
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    init_ram = 1'b0;
    @(negedge clk);

    // p0 write, then read back the same word
    q0.push_back(req_t'{1'b1, 9'h010, 32'hDEADBEEF});
    wait_quiet("t1_timeout", 50);
    q0.push_back(req_t'{1'b0, 9'h010, 32'h0});
    wait_quiet("t2_timeout", 50);
    chk("t2_p0_rdata", p0_rdata, 32'hDEADBEEF);
    chk("t2_p1_rdata", p1_rdata, 32'h0);

    // simultaneous requests, p0 re-requesting back to back
    ack_log.delete();
    q0.push_back(req_t'{1'b1, 9'h030, 32'h00000A0A});
    q0.push_back(req_t'{1'b0, 9'h030, 32'h0});
    q0.push_back(req_t'{1'b1, 9'h031, 32'h00000B0B});
    q1.push_back(req_t'{1'b1, 9'h040, 32'h00000C0C});
    wait_quiet("t3_timeout", 100);
    chk("t3_count", ack_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < ack_log.size()) chk($sformatf("t3_grant%0d", i), ack_log[i], exp_order[i]);
    end

    // p1 write arriving while p0 read is in WAIT
    ack_log.delete();
    q0.push_back(req_t'{1'b0, 9'h010, 32'h0});
    wait_model_wait("t4_wait_timeout", 20);
    q1.push_back(req_t'{1'b1, 9'h020, 32'h00001234});
    wait_quiet("t4_timeout", 50);
    chk("t4_count", ack_log.size(), 2);

    // asynchronous reset during a read
    q0.push_back(req_t'{1'b0, 9'h020, 32'h0});
    wait_model_wait("t5_wait_timeout", 20);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_busy",     busy,     1'b0);
    chk("t5_ram_re",   ram_re,   1'b0);
    chk("t5_p0_ack",   p0_ack,   1'b0);
    chk("t5_p1_ack",   p1_ack,   1'b0);
    chk("t5_p0_rdata", p0_rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ack_log.delete();
    repeat (6) @(negedge clk);
    chk("t5_no_ack", ack_log.size(), 0);
    q0.push_back(req_t'{1'b0, 9'h020, 32'h0});
    wait_quiet("t5_timeout", 50);
    chk("t5_rdata", p0_rdata, 32'h00001234);

    // loader burst then CPU read
    for (int i = 0; i < 8; i++) q1.push_back(req_t'{1'b1, AW'(i), DW'(i * 3)});
    wait_quiet("t6_burst_timeout", 200);
    q0.push_back(req_t'{1'b0, 9'h005, 32'h0});
    wait_quiet("t6_timeout", 50);
    chk("t6_rdata", p0_rdata, 32'd15);

    // random traffic on both ports
    rand_en = 1'b1;
    repeat (3000) @(negedge clk);
    rand_en = 1'b0;
    wait_quiet("rand_timeout", 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
